// File: rtl/cla_pkg.sv
// Shared constants and types for the 16-bit two-level carry-lookahead adder.
package cla_pkg;

    localparam int WIDTH      = 16;
    localparam int GROUP_W    = 4;
    localparam int NUM_GROUPS = WIDTH / GROUP_W;

    // Everything the adder registers on a clock edge, kept together so the
    // reset value and the captured value are always updated as one unit.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             g;
        logic             p;
    } cla_out_t;

    localparam cla_out_t CLA_OUT_RESET = '0;

endpackage : cla_pkg

// File: rtl/cla4_group.sv
// First-level lookahead group: 4-bit slice with internal carries in
// sum-of-products form, producing its sum bits plus group generate/propagate.
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               gg,
    output logic               gp
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    // Bit terms. p is the XOR form because it doubles as the half-sum.
    always_comb begin
        g = a & b;
        p = a ^ b;
    end

    // Internal carries, each fully expanded so no carry depends on the one
    // below it; c[0] is simply the carry into the group.
    always_comb begin
        c[0] = cin;
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
    end

    // Sum bits and the group terms handed up to the second level.
    // gg and gp deliberately ignore cin.
    always_comb begin
        s  = p ^ c;
        gg = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        gp = p[3] & p[2] & p[1] & p[0];
    end

endmodule : cla4_group

// File: rtl/cla_16.sv
// 16-bit two-level carry-lookahead adder with registered Sum, G and P.
// Datapath only: a new operand set is accepted on every rising edge and its
// result is visible one cycle later. There is no valid/ready handshake; every
// cycle carries an operation, and the cycle in which Rst_n is low is dropped.
module cla_16
    import cla_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             G,
    output logic             P
);

    logic [NUM_GROUPS-1:0] group_gg;
    logic [NUM_GROUPS-1:0] group_gp;
    logic [NUM_GROUPS-1:0] group_cin;
    logic [WIDTH-1:0]      sum_comb;
    logic                  c4;
    logic                  c8;
    logic                  c12;
    logic                  blk_g;
    logic                  blk_p;
    cla_out_t              out_d;
    cla_out_t              out_q;

    // Four first-level groups; each gets its carry from the second level.
    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_group
        cla4_group u_group (
            .a   (A[k*GROUP_W +: GROUP_W]),
            .b   (B[k*GROUP_W +: GROUP_W]),
            .cin (group_cin[k]),
            .s   (sum_comb[k*GROUP_W +: GROUP_W]),
            .gg  (group_gg[k]),
            .gp  (group_gp[k])
        );
    end

    // Second-level lookahead: group carries expanded over the group terms so
    // every boundary carry is two logic levels from the group outputs.
    always_comb begin
        c4  = group_gg[0]
            | (group_gp[0] & Cin);
        c8  = group_gg[1]
            | (group_gp[1] & group_gg[0])
            | (group_gp[1] & group_gp[0] & Cin);
        c12 = group_gg[2]
            | (group_gp[2] & group_gg[1])
            | (group_gp[2] & group_gp[1] & group_gg[0])
            | (group_gp[2] & group_gp[1] & group_gp[0] & Cin);
        group_cin = {c12, c8, c4, Cin};
    end

    // Block generate/propagate for a parent lookahead unit; neither uses Cin,
    // so the implied carry-out is G | (P & Cin).
    always_comb begin
        blk_g = group_gg[3]
              | (group_gp[3] & group_gg[2])
              | (group_gp[3] & group_gp[2] & group_gg[1])
              | (group_gp[3] & group_gp[2] & group_gp[1] & group_gg[0]);
        blk_p = group_gp[3] & group_gp[2] & group_gp[1] & group_gp[0];
    end

    // Gather the next register contents into one record.
    always_comb begin
        out_d     = CLA_OUT_RESET;
        out_d.sum = sum_comb;
        out_d.g   = blk_g;
        out_d.p   = blk_p;
    end

    // Output register; reset wins over the operand presented in that cycle.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_q <= CLA_OUT_RESET;
        end else begin
            out_q <= out_d;
        end
    end

    assign Sum = out_q.sum;
    assign G   = out_q.g;
    assign P   = out_q.p;

endmodule : cla_16

// File: tb/tb_cla_16.sv
// Bench for cla_16: directed vector table, then a back-to-back random stream
// with occasional mid-stream resets, scored against plain 17-bit arithmetic.
module tb_cla_16;

    localparam int NUM_RANDOM = 10000;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        g;
    logic        p;

    int tests_run;
    int tests_failed;

    // {cin, full[16:0], g, p} for each operation in flight
    logic [19:0] exp_q[$];

    typedef struct {
        string       name;
        logic        rst_n;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_g;
        logic        exp_p;
    } vec_t;

    vec_t vecs[12];

    cla_16 dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .Sum   (sum),
        .G     (g),
        .P     (p)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        cin   = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: present one operation on the falling edge
    task automatic drive(input logic r, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc);
        @(negedge clk);
        rst_n = r;
        a     = va;
        b     = vb;
        cin   = vc;
    endtask

    // reference model: the result of a + b + cin from plain arithmetic
    function automatic logic [19:0] model(input logic r, input logic [15:0] va,
                                          input logic [15:0] vb, input logic vc);
        logic [16:0] full;
        logic [16:0] no_cin;
        logic        mg;
        logic        mp;
        if (!r) return 20'h0;
        full   = {1'b0, va} + {1'b0, vb} + {16'h0, vc};
        no_cin = {1'b0, va} + {1'b0, vb};
        mg     = no_cin[16];
        mp     = ((va ^ vb) == 16'hFFFF);
        return {vc, full, mg, mp};
    endfunction

    initial begin
        logic [19:0] e;
        logic [16:0] e_full;
        logic [16:0] dut_full;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rr;
        int          mode;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{"reset_state",   1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{"after_reset",   1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[2]  = '{"full_ripple",   1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{"prop_cin1",     1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[4]  = '{"prop_cin0",     1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        vecs[5]  = '{"no_carry",      1'b1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6]  = '{"group_cross",   1'b1, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0};
        vecs[7]  = '{"reset_midrun",  1'b0, 16'h1234, 16'h4321, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{"zeros",         1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{"msb_gen",       1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{"alt_prop_cin",  1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{"carry_to_12",   1'b1, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

        // directed table, one operation per cycle
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(posedge clk);
            #1;
            check(vecs[i].name, {14'h0, sum, g, p},
                  {14'h0, vecs[i].exp_sum, vecs[i].exp_g, vecs[i].exp_p});
        end

        // hand sequence: back-to-back ops with a single reset cycle between
        drive(1'b1, 16'h0001, 16'h0002, 1'b0);
        @(posedge clk); #1;
        check("seq_op1", {14'h0, sum, g, p}, {14'h0, 16'h0003, 1'b0, 1'b0});
        drive(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        check("seq_rst", {14'h0, sum, g, p}, 32'h0);
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        check("seq_op3", {14'h0, sum, g, p}, {14'h0, 16'h0000, 1'b1, 1'b0});
        // outputs hold until the next edge even though inputs change
        @(negedge clk);
        a = 16'h1111;
        b = 16'h2222;
        #2;
        check("seq_hold", {14'h0, sum, g, p}, {14'h0, 16'h0000, 1'b1, 1'b0});

        // random back-to-back stream, scoreboarded through exp_q
        for (int i = 0; i < NUM_RANDOM; i++) begin
            mode = $urandom_range(0, 5);
            ra   = 16'($urandom_range(0, 16'hFFFF));
            rb   = 16'($urandom_range(0, 16'hFFFF));
            rc   = 1'($urandom_range(0, 1));
            case (mode)
                1: rb = ~ra;
                2: ra = 16'hFFFF;
                3: rb = 16'(16'h0 - ra);
                default: ;
            endcase
            rr = ((i % 997) == 500) ? 1'b0 : 1'b1;
            drive(rr, ra, rb, rc);
            exp_q.push_back(model(rr, ra, rb, rc));
            @(posedge clk);
            #1;
            e      = exp_q.pop_front();
            e_full = e[18:2];
            check("rand_sum_gp", {14'h0, sum, g, p}, {14'h0, e_full[15:0], e[1], e[0]});
            dut_full = {g | (p & e[19]), sum};
            check("rand_invariant", {15'h0, dut_full}, {15'h0, e_full});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_cla_16

// File: doc/cla_16.md
Name: cla_16

Overview:
- 16-bit two-level carry-lookahead adder with registered outputs.
- Produces Sum = A + B + Cin, plus group generate (G) and group propagate (P) for the whole 16-bit slice.
- G and P let a parent lookahead unit chain several slices into wider adders.
- Datapath leaf block; one clock domain.

Parameters:
- None. Width is fixed at 16 bits, organised as four 4-bit groups. Constants live in the shared package.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous reset, active-low
- A  input  16  addend
- B  input  16  addend
- Cin  input  1  carry into bit 0
- Sum  output  16  registered (A + B + Cin) mod 2^16
- G  output  1  registered 16-bit group generate
- P  output  1  registered 16-bit group propagate

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- Bit terms: g[i] = A[i] & B[i]; p[i] = A[i] ^ B[i].
  - XOR propagate is mandatory so that p also forms the sum bits.
- Level 1, each 4-bit group k = 0..3:
  - Internal carries c[i+1] = g[i] | p[i]&c[i], expanded in lookahead (sum-of-products) form, not rippled.
  - Group generate GG[k] = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Group propagate GP[k] = p3&p2&p1&p0.
- Level 2, group carries in lookahead form:
  - C4 = GG0 | GP0&Cin
  - C8 = GG1 | GP1&GG0 | GP1&GP0&Cin
  - C12 analogous, expanded the same way.
- Sum bits: s[i] = p[i] ^ c[i], with c[0] = Cin.
- Block outputs:
  - G = GG3 | GP3GG2 | GP3GP2GG1 | GP3GP2GP1GG0. G is independent of Cin.
  - P = GP3 & GP2 & GP1 & GP0, i.e. P = 1 iff A ^ B == 16'hFFFF. P is independent of Cin.
- Carry-out is not a port. The implied carry-out is G | (P & Cin).
- Invariant: {G | P&Cin, Sum} == A + B + Cin as a 17-bit value.
- Timing:
  - Inputs are combinational into the lookahead tree.
  - Sum, G and P are captured on the rising Clk edge.
  - Latency is 1 cycle; a new operation is accepted every cycle (fully pipelined, no handshake).
- Reset: when Rst_n = 0 at a rising edge, Sum = 16'h0000, G = 0, P = 0. Reset has priority over data.
- Reset mid-stream: the operand presented in the reset cycle is discarded. The first valid result appears one cycle after Rst_n returns high with operands applied.
- Outputs hold their value between edges. X on the inputs is not masked.
- Boundaries:
  - Overflow wraps modulo 2^16; the carry is visible only via G/P.
  - All-ones propagate with Cin = 1 gives Sum = 0 and P = 1.

Decomposition:
- Shared package cla_pkg: WIDTH = 16, GROUP_W = 4, NUM_GROUPS = 4.
- One sub-module, cla4_group:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], gg, gp.
  - Instantiated 4 times.
- Top level (cla_16) contains:
  - the second-level lookahead unit producing C4/C8/C12, G and P;
  - the output registers.

Test Plan:
- Rst_n = 0 with A = 16'hFFFF, B = 16'hFFFF, Cin = 1 -> after the edge, Sum = 0, G = 0, P = 0. Deassert reset -> next-edge result Sum = 16'hFFFF, G = 1, P = 0.
- A = 16'hFFFF, B = 16'h0001, Cin = 0 -> Sum = 16'h0000, G = 1, P = 0 (full carry chain ripples through all groups).
- A = 16'hFFFF, B = 16'h0000, Cin = 1 -> Sum = 16'h0000, G = 0, P = 1. Same operands with Cin = 0 -> Sum = 16'hFFFF, G = 0, P = 1.
- A = 16'h1234, B = 16'h4321, Cin = 0 -> Sum = 16'h5555, G = 0, P = 0. A = 16'h00FF, B = 16'h0F01, Cin = 1 -> Sum = 16'h1001, G = 0, P = 0 (carry across group boundaries 4/8).
- Back-to-back operands on consecutive cycles -> each result appears exactly one cycle later with no bubbles. Assert Rst_n low in the middle of the stream -> zeros for that cycle only.
- 10,000 random {A, B, Cin} vectors -> {G | P&Cin, Sum} == A + B + Cin. Also check P == &(A ^ B) and G == carry-out with Cin forced to 0.
